// File: rtl/cla_pipe_if.sv
// Handshake and operand/result bundle for cla_pipe.
// master drives operands and out_ready; slave (the adder) drives results and in_ready.
interface cla_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf, zf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf, zf
    );
endinterface

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES-bit segment per stage.
// Define CLA_PIPE_ZF_EN to build the registered zero flag; otherwise zf is tied low.
module cla_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input logic       clk,
    input logic       rst_n,
    cla_pipe_if.slave bus
);
    localparam int unsigned SEG    = WIDTH / STAGES;
    localparam int unsigned GROUPS = SEG / 4;
    localparam int unsigned PIPE   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int unsigned LAST   = STAGES - 1;

    // Two-level lookahead: carries inside each 4-bit group and between groups are
    // flattened generate/propagate sums, so no carry ripples through a group chain.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
        logic [SEG-1:0]    g;
        logic [SEG-1:0]    p;
        logic [SEG-1:0]    c;
        logic [GROUPS-1:0] gg;
        logic [GROUPS-1:0] gp;
        logic [GROUPS:0]   gc;
        logic              term;
        logic              cc;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < int'(GROUPS); j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                term = g[4*j+i];
                for (int m = i + 1; m < 4; m++) term = term & p[4*j+m];
                gg[j] = gg[j] | term;
            end
        end
        for (int j = 0; j <= int'(GROUPS); j++) begin
            cc = cin;
            for (int m = 0; m < j; m++) cc = cc & gp[m];
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) term = term & gp[m];
                cc = cc | term;
            end
            gc[j] = cc;
        end
        for (int j = 0; j < int'(GROUPS); j++) begin
            for (int i = 0; i < 4; i++) begin
                cc = gc[j];
                for (int m = 0; m < i; m++) cc = cc & p[4*j+m];
                for (int k = 0; k < i; k++) begin
                    term = g[4*j+k];
                    for (int m = k + 1; m < i; m++) term = term & p[4*j+m];
                    cc = cc | term;
                end
                c[4*j+i] = cc;
            end
        end
        return {gc[GROUPS], p ^ c};
    endfunction

    // Stage inputs (st_*) and stage results (r_*); stage k adds segment k.
    logic             st_vld [STAGES];
    logic             st_cy  [STAGES];
    logic             st_sub [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic [SEG:0]     seg_res[STAGES];
    logic [WIDTH-1:0] r_sum  [STAGES];
    logic             r_cy   [STAGES];

    // Inter-stage registers; the last stage writes the output registers instead.
    logic             p_vld_q[PIPE];
    logic             p_cy_q [PIPE];
    logic             p_sub_q[PIPE];
    logic [WIDTH-1:0] p_a_q  [PIPE];
    logic [WIDTH-1:0] p_b_q  [PIPE];
    logic [WIDTH-1:0] p_sum_q[PIPE];

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             adv;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        st_vld[0] = bus.in_valid;
        st_a[0]   = bus.a;
        st_b[0]   = bus.b;
        st_sub[0] = bus.sub;
        st_cy[0]  = bus.sub | bus.ci;
        st_sum[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            st_vld[k] = p_vld_q[k-1];
            st_a[k]   = p_a_q[k-1];
            st_b[k]   = p_b_q[k-1];
            st_sub[k] = p_sub_q[k-1];
            st_cy[k]  = p_cy_q[k-1];
            st_sum[k] = p_sum_q[k-1];
        end
        for (int k = 0; k < int'(STAGES); k++) begin
            seg_res[k] = seg_add(st_a[k][k*SEG +: SEG],
                                 st_b[k][k*SEG +: SEG] ^ {SEG{st_sub[k]}}, st_cy[k]);
            r_sum[k]   = st_sum[k];
            r_sum[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
            r_cy[k]    = seg_res[k][SEG];
        end
        ovf_d = (st_a[LAST][WIDTH-1] == (st_b[LAST][WIDTH-1] ^ st_sub[LAST])) &&
                (r_sum[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LAST); k++) begin
            if (!rst_n) begin
                p_vld_q[k] <= 1'b0;
            end else if (adv) begin
                p_vld_q[k] <= st_vld[k];
                p_a_q[k]   <= st_a[k];
                p_b_q[k]   <= st_b[k];
                p_sub_q[k] <= st_sub[k];
                p_cy_q[k]  <= r_cy[k];
                p_sum_q[k] <= r_sum[k];
            end
        end
    end

    // Result fields only load with a valid result so they stay at their last value otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= st_vld[LAST];
            if (st_vld[LAST]) begin
                s_q   <= r_sum[LAST];
                co_q  <= r_cy[LAST];
                ovf_q <= ovf_d;
            end
        end
    end

`ifdef CLA_PIPE_ZF_EN
    logic zf_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
        end else if (adv && st_vld[LAST]) begin
            zf_q <= (r_sum[LAST] == '0);
        end
    end
    assign bus.zf = zf_q;
`else
    assign bus.zf = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits; legal 4..128, multiple of 4.
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline register stages; legal 1..WIDTH/4, WIDTH divisible by 4*STAGES.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  operand set accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port ci  input  1  carry-in, add mode only.
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port s  output  WIDTH  sum/difference.
REQ-014 SHALL have port co  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port zf  output  1  result zero flag (see Configuration).

Function
REQ-017 SHALL compute, add mode: {co,s} = a + b + ci, modulo 2^(WIDTH+1).
REQ-018 SHALL compute, subtract mode: {co,s} = a + ~b + 1; ci ignored.
REQ-019 SHALL set ovf = (a_msb == b'_msb) && (s_msb != a_msb), where b' is the b actually added (inverted when sub=1).
REQ-020 SHALL split operands into STAGES equal segments of WIDTH/STAGES bits, LSB segment first; each stage adds one segment with 4-bit-group generate/propagate carry lookahead, no ripple across groups.
REQ-021 SHALL register, per stage, the segment carry-out plus all not-yet-added operand bits, already-computed sum bits, and the sub bit.
REQ-022 SHALL have latency exactly STAGES cycles from accept to out_valid when out_ready stays high.
REQ-023 SHALL sustain throughput of one result per cycle with out_ready held high.
REQ-024 SHALL advance the whole pipeline on the global condition adv = !out_valid || out_ready; in_ready = adv, combinationally.
REQ-025 SHALL hold every stage register, including s/co/ovf/zf, unchanged while adv is low; no result lost or duplicated.
REQ-026 SHALL let bubbles (invalid stages) propagate and not collapse them; per-stage valid bit travels with the data.
REQ-027 SHALL keep s, co, ovf, zf stable while out_valid=1 and out_ready=0.
REQ-028 SHALL ignore a, b, ci, sub when in_valid=0 or in_ready=0.
REQ-029 SHALL, for STAGES=1, register only the final result (single output stage).

Reset
REQ-030 SHALL, on rst_n low at a clk edge, clear all stage valid bits; out_valid=0, s=0, co=0, ovf=0, zf=0 from the next cycle.
REQ-031 SHALL discard in-flight operations when reset is asserted mid-operation; no result for them appears after reset.
REQ-032 SHALL drive in_ready=1 during and after reset (adv holds because out_valid=0); inputs presented while rst_n low are not accepted.

Configuration
REQ-033 SHALL honour macro CLA_PIPE_ZF_EN: when defined, zf = (s == 0), registered and aligned with s.
REQ-034 SHALL, without CLA_PIPE_ZF_EN, tie zf to constant 0 and synthesise no zero-detect logic; all other behaviour identical.

Verification (WIDTH=32, STAGES=2, out_ready=1 unless stated)
REQ-035 SHALL check add wrap: a=0xFFFFFFFF, b=0x00000000, ci=1, sub=0 -> 2 cycles later s=0x00000000, co=1, ovf=0, zf=1 (macro on).
REQ-036 SHALL check subtract: a=5, b=7, sub=1 -> s=0xFFFFFFFE, co=0, ovf=0, zf=0; a=7, b=7, sub=1 -> s=0, co=1, zf=1.
REQ-037 SHALL check overflow: a=0x7FFFFFFF, b=1, ci=0 -> s=0x80000000, ovf=1, co=0; a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, ovf=1, co=1.
REQ-038 SHALL check backpressure: issue 4 back-to-back ops, drop out_ready for 3 cycles when first result is valid -> in_ready=0 those cycles, outputs frozen, all 4 results delivered in order, none duplicated.
REQ-039 SHALL check reset mid-flight: accept 2 ops, assert rst_n=0 one cycle later -> out_valid=0, s=0 next cycle, neither result ever emitted.
REQ-040 SHALL check macro off: repeat REQ-035 without CLA_PIPE_ZF_EN -> identical s/co/ovf, zf=0.
